// File: rtl/chip8_timer_regs.sv
// chip8_timer_regs
//   CHIP-8 delay timer (DT) and sound timer (ST) registers with a buzzer tone
//   generator. Both timers count down once per 60 Hz tick and saturate at 0.
//   A CPU write to a timer takes priority over a simultaneous tick for that
//   timer only. While ST is non-zero the block outputs a square wave whose
//   half-period is HALF_PERIOD clock cycles.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active-high
//   tick_60hz    in   one-cycle 60 Hz pulse from the timer block
//   wr_en        in   CPU write strobe
//   wr_sel       in   write target: 0 = DT, 1 = ST
//   wr_data      in   [7:0] value to load
//   dt_value     out  [7:0] current DT
//   st_value     out  [7:0] current ST
//   dt_zero      out  DT == 0
//   sound_active out  ST != 0
//   tone_out     out  buzzer square wave, 0 while silent
module chip8_timer_regs #(
  parameter int CLOCK_SPEED = 100000,
  parameter int TONE_HZ     = 440,
  parameter int HALF_PERIOD = CLOCK_SPEED / (2 * TONE_HZ)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_60hz,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [7:0] wr_data,
  output logic [7:0] dt_value,
  output logic [7:0] st_value,
  output logic       dt_zero,
  output logic       sound_active,
  output logic       tone_out
);

  localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

  logic [7:0]       dt_reg;
  logic [7:0]       st_reg;
  logic [CNT_W-1:0] tone_cnt;
  logic             tone_reg;

  // Timer decrement that sticks at zero instead of wrapping to 255.
  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

  // Timer registers: write beats tick, evaluated per register.
  always_ff @(posedge clk) begin
    if (rst) begin
      dt_reg <= 8'd0;
      st_reg <= 8'd0;
    end else begin
      if (wr_en && !wr_sel)
        dt_reg <= wr_data;
      else if (tick_60hz)
        dt_reg <= sat_dec(dt_reg);

      if (wr_en && wr_sel)
        st_reg <= wr_data;
      else if (tick_60hz)
        st_reg <= sat_dec(st_reg);
    end
  end

  // Tone generator: free-runs only while sounding, so a rewrite of a
  // non-zero ST keeps the current phase; silence clears it for a clean start.
  always_ff @(posedge clk) begin
    if (rst) begin
      tone_cnt <= '0;
      tone_reg <= 1'b0;
    end else if (!sound_active) begin
      tone_cnt <= '0;
      tone_reg <= 1'b0;
    end else if (tone_cnt == CNT_LAST) begin
      tone_cnt <= '0;
      tone_reg <= ~tone_reg;
    end else begin
      tone_cnt <= tone_cnt + 1'b1;
    end
  end

  assign dt_value     = dt_reg;
  assign st_value     = st_reg;
  assign dt_zero      = (dt_reg == 8'd0);
  assign sound_active = (st_reg != 8'd0);
  assign tone_out     = tone_reg;

endmodule

// File: tb/tb_chip8_timer_regs.sv
module tb_chip8_timer_regs;

  localparam int HP = 100000 / (2 * 440);  // 113
  localparam int TICK_GAP = 100;           // compressed 60 Hz period for the soak

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_60hz = 1'b0;
  logic       wr_en = 1'b0;
  logic       wr_sel = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic [7:0] dt_value;
  logic [7:0] st_value;
  logic       dt_zero;
  logic       sound_active;
  logic       tone_out;

  int n_chk = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  // Behavioural reference: timer values as integers, and the tone expressed
  // as the number of clock edges the sound has been continuously on.
  int m_dt = 0;
  int m_st = 0;
  int m_on = 0;

  chip8_timer_regs dut (
    .clk(clk), .rst(rst), .tick_60hz(tick_60hz), .wr_en(wr_en),
    .wr_sel(wr_sel), .wr_data(wr_data), .dt_value(dt_value),
    .st_value(st_value), .dt_zero(dt_zero), .sound_active(sound_active),
    .tone_out(tone_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_dt = 0; m_st = 0; m_on = 0;
    end else begin
      if (m_st != 0) m_on = m_on + 1; else m_on = 0;
      if (wr_en && !wr_sel) m_dt = wr_data;
      else if (tick_60hz && m_dt > 0) m_dt = m_dt - 1;
      if (wr_en && wr_sel) m_st = wr_data;
      else if (tick_60hz && m_st > 0) m_st = m_st - 1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_dt", dt_value, m_dt);
      chk("model_st", st_value, m_st);
      chk("model_dt_zero", dt_zero, (m_dt == 0) ? 1 : 0);
      chk("model_sound", sound_active, (m_st != 0) ? 1 : 0);
      chk("model_tone", tone_out, (m_on / HP) % 2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_write(input logic sel, input logic [7:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_data = data;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_tick();
    tick_60hz = 1'b1;
    step();
    tick_60hz = 1'b0;
  endtask

  initial begin
    step();
    check_en = 1'b1;
    rst = 1'b0;

    // Reset after arbitrary writes
    do_write(1'b0, 8'd77);
    do_write(1'b1, 8'd42);
    steps(3);
    rst = 1'b1; wr_en = 1'b1; wr_sel = 1'b1; wr_data = 8'd9; tick_60hz = 1'b1;
    steps(2);
    rst = 1'b0; wr_en = 1'b0; tick_60hz = 1'b0;
    chk("rst_dt", dt_value, 0);
    chk("rst_st", st_value, 0);
    chk("rst_dt_zero", dt_zero, 1);
    chk("rst_sound", sound_active, 0);
    chk("rst_tone", tone_out, 0);

    // Load and countdown with saturation
    do_write(1'b0, 8'd3);
    chk("cd_load", dt_value, 3);
    chk("cd_zero_lo", dt_zero, 0);
    do_tick(); chk("cd_t1", dt_value, 2);
    do_tick(); chk("cd_t2", dt_value, 1);
    chk("cd_zero_still_lo", dt_zero, 0);
    do_tick(); chk("cd_t3", dt_value, 0);
    chk("cd_zero_hi", dt_zero, 1);
    do_tick(); chk("cd_t4_sat", dt_value, 0);

    // Write/tick collision
    do_write(1'b0, 8'd5);
    do_write(1'b1, 8'd5);
    wr_en = 1'b1; wr_sel = 1'b1; wr_data = 8'd9; tick_60hz = 1'b1;
    step();
    wr_en = 1'b0; tick_60hz = 1'b0;
    chk("col_st", st_value, 9);
    chk("col_dt", dt_value, 4);
    do_write(1'b1, 8'd0);
    step();

    // Sound and tone
    do_write(1'b1, 8'd2);
    chk("snd_active", sound_active, 1);
    chk("snd_tone0", tone_out, 0);
    steps(HP - 1);
    chk("snd_tone_before", tone_out, 0);
    step();
    chk("snd_tone_first", tone_out, 1);
    steps(HP - 1);
    chk("snd_tone_hold", tone_out, 1);
    step();
    chk("snd_tone_second", tone_out, 0);
    steps(50);
    do_tick(); chk("snd_st1", st_value, 1);
    do_tick(); chk("snd_st0", st_value, 0);
    chk("snd_off", sound_active, 0);
    step();
    chk("snd_tone_off", tone_out, 0);

    // Sound cutoff while tone high
    do_write(1'b1, 8'd50);
    steps(HP + 5);
    chk("cut_tone_hi", tone_out, 1);
    do_write(1'b1, 8'd0);
    chk("cut_sound", sound_active, 0);
    step();
    chk("cut_tone", tone_out, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      wr_en = ($urandom_range(0, 29) == 0);
      wr_sel = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0: wr_data = 8'd0;
        1: wr_data = 8'd1;
        2: wr_data = 8'd255;
        default: wr_data = 8'($urandom_range(2, 12));
      endcase
      tick_60hz = ($urandom_range(0, 39) == 0);
      step();
    end
    rst = 1'b0; wr_en = 1'b0; tick_60hz = 1'b0;

    // Full-rate soak: 4 s worth of ticks with DT=255, ST sounding throughout
    do_write(1'b1, 8'd255);
    do_write(1'b0, 8'd255);
    for (int t = 1; t <= 255; t++) begin
      steps(TICK_GAP - 1);
      do_tick();
      if (t == 240) chk("soak_4s", dt_value, 15);
    end
    chk("soak_end", dt_value, 0);
    chk("soak_zero", dt_zero, 1);
    do_tick();
    chk("soak_sat", dt_value, 0);
    steps(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
